cvt_int_to_float_pipe: RTL and testbench
========================================

# cvt_int_to_float_pipe

Pipelined, parametrised integer-to-floating-point converter for the Float Processing Unit. It accepts one signed integer per cycle, or one unsigned integer when that mode is compiled in, over a valid/ready handshake. It normalises, rounds under a per-transaction rounding mode, and returns a packed sign/exponent/fraction word with inexact and overflow flags three cycles later. It replaces the single-cycle combinational converter on the FPU issue path and supports any width ratio between integer and float formats.

## Interface

**Parameters**
- `INTN`, 32: integer operand width (≥ 2).
- `NEXP`, 8: exponent field width; `BIAS` = 2^(NEXP-1) − 1.
- `NSIG`, 23: stored fraction width (hidden bit excluded).

**Ports**
- `clk`, in, 1: clock. One clock for the whole block.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `in_valid`, in, 1: operand valid.
- `in_ready`, out, 1: block accepts an operand this cycle.
- `in_data`, in, INTN: integer operand.
- `in_rm`, in, 3: rounding mode.
  - 0 = RNE (nearest, ties to even)
  - 1 = RTZ (toward zero)
  - 2 = RDN (toward −inf)
  - 3 = RUP (toward +inf)
  - 4 = RMM (nearest, ties away)
  - 5–7 are treated as RNE.
- `in_unsigned`, in, 1: operand is unsigned. Present only with `CVT_UNSIGNED_EN`.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts the result.
- `out_data`, out, 1+NEXP+NSIG: result word, laid out as {sign, exponent, fraction}.
- `out_inexact`, out, 1: the result differs from the exact value.
- `out_overflow`, out, 1: the rounded exponent reached all-ones.

## Operation

- **Transfer rule:** an input transfer occurs when `in_valid && in_ready`. An output transfer occurs when `out_valid && out_ready`.
- **Stage 1 (capture):**
  - Register the sign: `in_data[INTN-1]` when signed, 0 when unsigned.
  - Register the magnitude: two's-complement absolute value as an unsigned INTN value. −2^(INTN-1) yields the magnitude 2^(INTN-1).
  - Register `in_rm` alongside.
- **Stage 2 (normalise):**
  - Compute `lzc`, the leading-zero count of the magnitude, as a log-depth count.
  - Shift the magnitude left by `lzc` so the MSB is 1.
  - Compute the biased exponent `e = INTN-1-lzc+BIAS`, at width NEXP+1 so it cannot wrap.
- **Stage 3 (round and pack):**
  - Fraction = bits below the MSB, truncated to NSIG bits.
  - Guard = the next bit down; sticky = OR of all remaining bits.
  - When NSIG ≥ INTN-1, guard and sticky are 0.
  - Round-up decision:
    - RNE: `G & (S | lsb)`.
    - RMM: `G`.
    - RUP: `(G|S) & !sign`.
    - RDN: `(G|S) & sign`.
    - RTZ: never.
  - A fraction carry-out sets the fraction to 0 and adds 1 to `e`.
  - Inexact = `G | S`.
- **Overflow:** applies when the rounded `e` ≥ 2^NEXP − 1.
  - `out_overflow` = 1 and `out_inexact` = 1.
  - The result is ±infinity (exponent all-ones, fraction 0) for RNE and RMM, for RUP with a positive result, and for RDN with a negative result.
  - Otherwise the result is ±max finite (exponent 2^NEXP − 2, fraction all-ones).
- **Zero input:** output is +0 (all zero bits) with both flags 0, in every mode.
- **Results are always normal:** no subnormal or NaN output is ever produced.

## Timing

- **Latency:** 3 cycles from input transfer to `out_valid` when not stalled. Throughput is 1 per cycle.
- **Pipeline advance:** governed by a single enable, `adv = !out_valid || out_ready`.
  - All stage registers load only when `adv` is high.
  - Bubbles are not compressed.
- **Ready:** `in_ready = adv`, combinational from `out_valid` and `out_ready`.
- **Output stability:** while `out_valid && !out_ready`, `out_data` and both flags hold stable and no input is accepted.
- **Ordering:** results leave in input order. There is no reordering and no drop.
- **Reset:** while `rst_n` is low, all stage valids are 0, `out_valid` = 0, `out_data` = 0 and both flags are 0.
  - Asserting reset mid-operation discards all in-flight operands.
  - The first accepted operand after reset appears 3 cycles after its transfer.
- **Simultaneous events:** an output transfer and an input transfer in the same cycle are legal and sustain full rate.
- **Mode sampling:** `in_rm` and `in_unsigned` are sampled only on the input transfer. Changes at any other time have no effect.

## Configuration

- **Macro:** `CVT_UNSIGNED_EN`.
- **Defined:**
  - The `in_unsigned` port exists.
  - When it is high, the operand is taken as unsigned, the sign is forced to 0 and no negation occurs. For example, 0xFFFFFFFF converts to 0x4F800000 under RNE.
- **Not defined:**
  - The port is absent and every operand is signed.
  - No unsigned logic is instantiated.

## Test plan

Defaults (INTN=32, NEXP=8, NSIG=23) apply unless a line states otherwise.

- **Basic signed conversion, RNE:** `in_data`=1 → 0x3F800000. `in_data`=0xFFFFFFFF → 0xBF800000. `in_data`=0 → 0x00000000. All three have both flags 0.
- **Rounding modes on 0x7FFFFFFF:**
  - RNE → 0x4F000000, inexact=1.
  - RTZ → 0x4EFFFFFF, inexact=1.
  - RUP → 0x4F000000.
  - RDN → 0x4EFFFFFF.
- **Most negative input:** `in_data`=0x80000000 → 0xCF000000, both flags 0.
- **Backpressure:**
  - Stimulus: stream 6 operands back-to-back while `out_ready` is held low from cycle 4 to cycle 9.
  - Required: `in_ready` is low exactly while `out_valid && !out_ready`; output holds stable throughout; all 6 results arrive in order with none lost or duplicated.
- **Overflow (INTN=32, NEXP=5, NSIG=10):**
  - `in_data`=70000 under RNE → 0x7C00, overflow=1, inexact=1.
  - Same input under RTZ → 0x7BFF, overflow=1.
  - −70000 under RUP → 0xFBFF.
- **Reset mid-stream:**
  - Stimulus: pulse `rst_n` low with 3 operands in flight.
  - Required: `out_valid` drops asynchronously; no stale result emerges afterwards; the next operand's result appears 3 cycles after its transfer.

Source files
------------

// File: rtl/cvt_int_to_float_pipe.sv
// ---------------------------------------------------------------------------
// cvt_int_to_float_pipe
//
// Three-stage pipelined integer-to-floating-point converter with a
// valid/ready handshake on both sides.
//   Stage 1: capture the sign, the two's-complement magnitude and the
//            rounding mode.
//   Stage 2: find the leading-zero count (log-depth), normalise the
//            magnitude and form the biased exponent.
//   Stage 3: round under the captured mode, pack the result and raise
//            the flags. This stage's registers drive the outputs.
// The whole pipe advances on one enable, adv = !out_valid || out_ready.
//
// Optional feature: define CVT_UNSIGNED_EN to add the in_unsigned port.
// When it is high the operand is taken as unsigned.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   in_valid     operand valid
//   in_ready     operand accepted this cycle (equals adv)
//   in_data      integer operand, INTN bits
//   in_rm        rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 5-7 RNE
//   in_unsigned  operand is unsigned (only with CVT_UNSIGNED_EN)
//   out_valid    result valid
//   out_ready    consumer accepts the result
//   out_data     {sign, exponent, fraction}, 1+NEXP+NSIG bits
//   out_inexact  result differs from the exact value
//   out_overflow rounded exponent reached all-ones
// ---------------------------------------------------------------------------
module cvt_int_to_float_pipe #(
    parameter int INTN = 32,
    parameter int NEXP = 8,
    parameter int NSIG = 23
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INTN-1:0]    in_data,
    input  logic [2:0]         in_rm,
`ifdef CVT_UNSIGNED_EN
    input  logic               in_unsigned,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NEXP+NSIG:0] out_data,
    output logic               out_inexact,
    output logic               out_overflow
);

    localparam int OW    = 1 + NEXP + NSIG;
    localparam int BIAS  = (32'd1 << (NEXP - 1)) - 32'd1;
    localparam int LVL   = $clog2(INTN);
    localparam int P     = 32'd1 << LVL;
    localparam int EMAXI = (32'd1 << NEXP) - 32'd1;
    // The exponent is kept wide enough that the largest value it can
    // take, including the rounding carry, never wraps.
    localparam int EW0   = $clog2(INTN + BIAS + 1) + 1;
    localparam int EW    = (EW0 > NEXP + 1) ? EW0 : NEXP + 1;
    localparam int XW    = INTN + NSIG + 1;

    localparam logic [EW-1:0] EMAX_E = EW'(EMAXI);
    localparam logic [EW-1:0] ETOP_E = EW'(INTN - 1 + BIAS);

    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    // Log-depth normalise: at each level test the top 2^k bits of the
    // window; if they are all zero, shift them out and set bit k of the
    // count. Returns {lzc, bits below the leading one}.
    function automatic logic [LVL+INTN-2:0] norm_f(input logic [INTN-1:0] m);
        logic [P-1:0]   v;
        logic [P-1:0]   mask;
        logic [LVL-1:0] c;
        v = P'(m) << (P - INTN);
        c = '0;
        for (int k = LVL - 1; k >= 0; k--) begin
            mask = ~({P{1'b1}} >> (32'd1 << k));
            if ((v & mask) == '0) begin
                v    = v << (32'd1 << k);
                c[k] = 1'b1;
            end else begin
                c[k] = 1'b0;
            end
        end
        return {c, v[P-2 -: INTN-1]};
    endfunction

    logic                 adv_s;
    logic                 sign_in_s;
    logic [INTN-1:0]      mag_in_s;

    logic                 v1_q, v1_d, sign1_q, sign1_d;
    logic [INTN-1:0]      mag1_q, mag1_d;
    logic [2:0]           rm1_q, rm1_d;

    logic [LVL+INTN-2:0]  norm_s;
    logic [LVL-1:0]       lzc_s;
    logic [INTN-2:0]      mant_s;
    logic [EW-1:0]        exp_s;

    logic                 v2_q, v2_d, sign2_q, sign2_d, zero2_q, zero2_d;
    logic [2:0]           rm2_q, rm2_d;
    logic [INTN-2:0]      mant2_q, mant2_d;
    logic [EW-1:0]        exp2_q, exp2_d;

    logic [XW-1:0]        ext_s;
    logic [NSIG-1:0]      frac_s;
    logic                 guard_s, sticky_s, up_s, inf_s, ovf_s, inx_s;
    logic [NSIG:0]        frac_inc_s;
    logic [EW-1:0]        exp_rnd_s;
    logic [OW-1:0]        res_s;

    logic                 out_valid_q, out_valid_d;
    logic [OW-1:0]        out_data_q, out_data_d;
    logic                 out_inexact_q, out_inexact_d;
    logic                 out_overflow_q, out_overflow_d;

    assign adv_s        = !out_valid_q || out_ready;
    assign in_ready     = adv_s;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_inexact  = out_inexact_q;
    assign out_overflow = out_overflow_q;

    // Stage 1 next state: sign and absolute value of the incoming operand.
    always_comb begin
`ifdef CVT_UNSIGNED_EN
        if (in_unsigned) begin
            sign_in_s = 1'b0;
        end else begin
            sign_in_s = in_data[INTN-1];
        end
`else
        sign_in_s = in_data[INTN-1];
`endif
        // The most negative value negates to itself, which read as
        // unsigned is exactly its magnitude.
        if (sign_in_s) begin
            mag_in_s = (~in_data) + {{(INTN-1){1'b0}}, 1'b1};
        end else begin
            mag_in_s = in_data;
        end
        if (adv_s) begin
            v1_d    = in_valid;
            sign1_d = sign_in_s;
            mag1_d  = mag_in_s;
            rm1_d   = in_rm;
        end else begin
            v1_d    = v1_q;
            sign1_d = sign1_q;
            mag1_d  = mag1_q;
            rm1_d   = rm1_q;
        end
    end

    // Stage 2 next state: normalised magnitude and biased exponent.
    always_comb begin
        norm_s = norm_f(mag1_q);
        lzc_s  = norm_s[LVL+INTN-2 -: LVL];
        mant_s = norm_s[INTN-2:0];
        exp_s  = ETOP_E - EW'(lzc_s);
        if (adv_s) begin
            v2_d    = v1_q;
            sign2_d = sign1_q;
            zero2_d = (mag1_q == '0);
            rm2_d   = rm1_q;
            mant2_d = mant_s;
            exp2_d  = exp_s;
        end else begin
            v2_d    = v2_q;
            sign2_d = sign2_q;
            zero2_d = zero2_q;
            rm2_d   = rm2_q;
            mant2_d = mant2_q;
            exp2_d  = exp2_q;
        end
    end

    // Stage 3 next state: round, detect overflow and pack the result.
    always_comb begin
        // Zero padding below the magnitude makes fraction/guard/sticky
        // extraction uniform for any INTN/NSIG ratio: when the fraction is
        // wider than the magnitude, guard and sticky fall in the padding.
        ext_s    = {mant2_q, {(NSIG + 2){1'b0}}};
        frac_s   = ext_s[XW-1 -: NSIG];
        guard_s  = ext_s[XW-1-NSIG];
        sticky_s = |ext_s[XW-2-NSIG:0];

        case (rm2_q)
            RM_RTZ:  up_s = 1'b0;
            RM_RDN:  up_s = (guard_s | sticky_s) & sign2_q;
            RM_RUP:  up_s = (guard_s | sticky_s) & !sign2_q;
            RM_RMM:  up_s = guard_s;
            default: up_s = guard_s & (sticky_s | frac_s[0]);
        endcase

        // A carry out leaves the low NSIG bits at zero, so only the
        // exponent needs the increment.
        frac_inc_s = {1'b0, frac_s} + {{NSIG{1'b0}}, up_s};
        exp_rnd_s  = exp2_q + EW'(frac_inc_s[NSIG]);
        ovf_s      = (exp_rnd_s >= EMAX_E);

        // Overflow saturates to max finite when the mode rounds toward zero
        // for this sign; otherwise it goes to infinity.
        case (rm2_q)
            RM_RTZ:  inf_s = 1'b0;
            RM_RDN:  inf_s = sign2_q;
            RM_RUP:  inf_s = !sign2_q;
            default: inf_s = 1'b1;
        endcase

        if (zero2_q) begin
            res_s = '0;
            inx_s = 1'b0;
        end else if (ovf_s) begin
            if (inf_s) begin
                res_s = {sign2_q, {NEXP{1'b1}}, {NSIG{1'b0}}};
            end else begin
                res_s = {sign2_q, {(NEXP-1){1'b1}}, 1'b0, {NSIG{1'b1}}};
            end
            inx_s = 1'b1;
        end else begin
            res_s = {sign2_q, exp_rnd_s[NEXP-1:0], frac_inc_s[NSIG-1:0]};
            inx_s = guard_s | sticky_s;
        end

        if (adv_s) begin
            out_valid_d    = v2_q;
            out_data_d     = res_s;
            out_inexact_d  = inx_s;
            out_overflow_d = ovf_s & !zero2_q;
        end else begin
            out_valid_d    = out_valid_q;
            out_data_d     = out_data_q;
            out_inexact_d  = out_inexact_q;
            out_overflow_d = out_overflow_q;
        end
    end

    // Pipeline state registers; reset empties the pipe and clears the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q           <= 1'b0;
            sign1_q        <= 1'b0;
            mag1_q         <= '0;
            rm1_q          <= 3'd0;
            v2_q           <= 1'b0;
            sign2_q        <= 1'b0;
            zero2_q        <= 1'b0;
            rm2_q          <= 3'd0;
            mant2_q        <= '0;
            exp2_q         <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_inexact_q  <= 1'b0;
            out_overflow_q <= 1'b0;
        end else begin
            v1_q           <= v1_d;
            sign1_q        <= sign1_d;
            mag1_q         <= mag1_d;
            rm1_q          <= rm1_d;
            v2_q           <= v2_d;
            sign2_q        <= sign2_d;
            zero2_q        <= zero2_d;
            rm2_q          <= rm2_d;
            mant2_q        <= mant2_d;
            exp2_q         <= exp2_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_inexact_q  <= out_inexact_d;
            out_overflow_q <= out_overflow_d;
        end
    end

endmodule

// File: tb/tb_cvt_int_to_float_pipe.sv
// ---------------------------------------------------------------------------
// Self-checking bench for cvt_int_to_float_pipe.
// Two instances: the default single-precision format and a narrow
// NEXP=5/NSIG=10 format used for the overflow cases. Expected results are
// pushed to a per-instance queue at each input transfer and compared in
// order at each output transfer.
// ---------------------------------------------------------------------------
module tb_cvt_int_to_float_pipe;

    typedef struct packed {
        logic [63:0] data;
        logic        inx;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data;
    logic [2:0]  in_rm;
    logic        in_unsigned;
    logic [31:0] out_data;
    logic        out_inexact, out_overflow;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [31:0] h_in_data;
    logic [2:0]  h_in_rm;
    logic        h_in_unsigned;
    logic [15:0] h_out_data;
    logic        h_out_inexact, h_out_overflow;

    exp_t sb[$];
    exp_t sbh[$];
    exp_t drv_exp, h_drv_exp;
    int   n_checks = 0;
    int   n_errors = 0;
    int   stall_seen = 0;
    logic rnd_done;

    always #5 clk = ~clk;

    cvt_int_to_float_pipe #(.INTN(32), .NEXP(8), .NSIG(23)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rm(in_rm),
`ifdef CVT_UNSIGNED_EN
        .in_unsigned(in_unsigned),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_inexact(out_inexact), .out_overflow(out_overflow)
    );

    cvt_int_to_float_pipe #(.INTN(32), .NEXP(5), .NSIG(10)) u_dut_h (
        .clk(clk), .rst_n(rst_n),
        .in_valid(h_in_valid), .in_ready(h_in_ready), .in_data(h_in_data), .in_rm(h_in_rm),
`ifdef CVT_UNSIGNED_EN
        .in_unsigned(h_in_unsigned),
`endif
        .out_valid(h_out_valid), .out_ready(h_out_ready), .out_data(h_out_data),
        .out_inexact(h_out_inexact), .out_overflow(h_out_overflow)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, expv, $time);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] d, input logic inx, input logic ovf);
        exp_t r;
        r.data = d;
        r.inx  = inx;
        r.ovf  = ovf;
        return r;
    endfunction

    // Reference: integer quotient/remainder rounding, independent of bit-level guard/sticky.
    function automatic exp_t model(input logic [31:0] din, input logic [2:0] rm, input logic uns,
                                   input int nexp, input int nsig);
        exp_t r;
        logic sgn, exact, up, inf;
        longint unsigned mag, q, rem, half, ex, fr;
        int p, e, bias, sh, emax;
        r     = '0;
        sgn   = uns ? 1'b0 : din[31];
        mag   = sgn ? (64'h1_0000_0000 - {32'd0, din}) : {32'd0, din};
        if (mag == 64'd0) return r;
        p = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        bias  = (1 << (nexp - 1)) - 1;
        e     = p + bias;
        exact = 1'b1;
        if (p > nsig) begin
            sh    = p - nsig;
            q     = mag >> sh;
            rem   = mag - (q << sh);
            half  = 64'd1 << (sh - 1);
            exact = (rem == 64'd0);
            case (rm)
                3'd1:    up = 1'b0;
                3'd2:    up = !exact && sgn;
                3'd3:    up = !exact && !sgn;
                3'd4:    up = (rem >= half);
                default: up = (rem > half) || ((rem == half) && q[0]);
            endcase
            q = q + 64'(up);
            if (q == (64'd1 << (nsig + 1))) begin
                q = q >> 1;
                e++;
            end
        end else begin
            q = mag << (nsig - p);
        end
        emax = (1 << nexp) - 1;
        if (e >= emax) begin
            r.ovf = 1'b1;
            r.inx = 1'b1;
            case (rm)
                3'd1:    inf = 1'b0;
                3'd2:    inf = sgn;
                3'd3:    inf = !sgn;
                default: inf = 1'b1;
            endcase
            ex = inf ? 64'(emax) : 64'(emax - 1);
            fr = inf ? 64'd0 : ((64'd1 << nsig) - 64'd1);
        end else begin
            r.inx = !exact;
            ex    = 64'(e);
            fr    = q - (64'd1 << nsig);
        end
        r.data = ({63'd0, sgn} << (nexp + nsig)) | (ex << nsig) | fr;
        return r;
    endfunction

    task automatic send(input logic [31:0] d, input logic [2:0] rm, input logic uns, input exp_t e);
        logic ok;
        int   guard;
        in_valid    = 1'b1;
        in_data     = d;
        in_rm       = rm;
        in_unsigned = uns;
        drv_exp     = e;
        ok          = 1'b0;
        guard       = 0;
        while (!ok && guard < 500) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!ok) check_val("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [31:0] d, input logic [2:0] rm, input logic uns);
        send(d, rm, uns, model(d, rm, uns, 8, 23));
    endtask

    task automatic send_h(input logic [31:0] d, input logic [2:0] rm, input exp_t e);
        logic ok;
        int   guard;
        h_in_valid = 1'b1;
        h_in_data  = d;
        h_in_rm    = rm;
        h_drv_exp  = e;
        ok         = 1'b0;
        guard      = 0;
        while (!ok && guard < 500) begin
            @(negedge clk);
            ok = h_in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!ok) check_val("send_h_timeout", 64'd0, 64'd1);
        h_in_valid = 1'b0;
    endtask

    task automatic rand_op(output logic [31:0] d, output logic [2:0] rm);
        d = $urandom;
        d = d >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) d = -d;
        rm = 3'($urandom_range(0, 7));
    endtask

    // Main-instance monitor: scoreboard, ready rule and output hold while stalled.
    initial begin
        exp_t e, held;
        logic stall_prev;
        stall_prev = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                stall_prev = 1'b0;
            end else begin
                check_val("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
                if (stall_prev) begin
                    check_val("hold_valid", 64'(out_valid), 64'd1);
                    check_val("hold_data", 64'(out_data), held.data);
                    check_val("hold_inx", 64'(out_inexact), 64'(held.inx));
                    check_val("hold_ovf", 64'(out_overflow), 64'(held.ovf));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check_val("sb_underflow", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check_val("res_data", 64'(out_data), e.data);
                        check_val("res_inexact", 64'(out_inexact), 64'(e.inx));
                        check_val("res_overflow", 64'(out_overflow), 64'(e.ovf));
                    end
                end
                if (in_valid && in_ready) sb.push_back(drv_exp);
                stall_prev = out_valid && !out_ready;
                if (stall_prev) stall_seen++;
                held = mk(64'(out_data), out_inexact, out_overflow);
            end
        end
    end

    // Narrow-format monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sbh.delete();
            end else begin
                if (h_out_valid && h_out_ready) begin
                    if (sbh.size() == 0) begin
                        check_val("h_sb_underflow", 64'd1, 64'd0);
                    end else begin
                        e = sbh.pop_front();
                        check_val("h_res_data", 64'(h_out_data), e.data);
                        check_val("h_res_inexact", 64'(h_out_inexact), 64'(e.inx));
                        check_val("h_res_overflow", 64'(h_out_overflow), 64'(e.ovf));
                    end
                end
                if (h_in_valid && h_in_ready) sbh.push_back(h_drv_exp);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [2:0]  rm;
        logic        u;
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = 32'd0; in_rm = 3'd0; in_unsigned = 1'b0; out_ready = 1'b1;
        h_in_valid = 1'b0; h_in_data = 32'd0; h_in_rm = 3'd0; h_in_unsigned = 1'b0; h_out_ready = 1'b1;
        drv_exp = '0; h_drv_exp = '0; rnd_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_data", 64'(out_data), 64'd0);
        check_val("rst_inexact", 64'(out_inexact), 64'd0);
        check_val("rst_overflow", 64'(out_overflow), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First-transfer latency: valid after the third edge counting the transfer edge.
        send(32'd1, 3'd0, 1'b0, mk(64'h3F80_0000, 1'b0, 1'b0));
        check_val("lat_e0", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check_val("lat_e1", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check_val("lat_e2", 64'(out_valid), 64'd1);

        // Directed values.
        send(32'hFFFF_FFFF, 3'd0, 1'b0, mk(64'hBF80_0000, 1'b0, 1'b0));
        send(32'h0000_0000, 3'd0, 1'b0, mk(64'h0000_0000, 1'b0, 1'b0));
        send(32'h0000_0000, 3'd3, 1'b0, mk(64'h0000_0000, 1'b0, 1'b0));
        send(32'h7FFF_FFFF, 3'd0, 1'b0, mk(64'h4F00_0000, 1'b1, 1'b0));
        send(32'h7FFF_FFFF, 3'd1, 1'b0, mk(64'h4EFF_FFFF, 1'b1, 1'b0));
        send(32'h7FFF_FFFF, 3'd3, 1'b0, mk(64'h4F00_0000, 1'b1, 1'b0));
        send(32'h7FFF_FFFF, 3'd2, 1'b0, mk(64'h4EFF_FFFF, 1'b1, 1'b0));
        send(32'h7FFF_FFFF, 3'd4, 1'b0, mk(64'h4F00_0000, 1'b1, 1'b0));
        send(32'h7FFF_FFFF, 3'd7, 1'b0, mk(64'h4F00_0000, 1'b1, 1'b0));
        send(32'h8000_0000, 3'd0, 1'b0, mk(64'hCF00_0000, 1'b0, 1'b0));
        send(32'h0100_0001, 3'd0, 1'b0, mk(64'h4B80_0000, 1'b1, 1'b0));
        send(32'h0100_0001, 3'd4, 1'b0, mk(64'h4B80_0001, 1'b1, 1'b0));
`ifdef CVT_UNSIGNED_EN
        send(32'hFFFF_FFFF, 3'd0, 1'b1, mk(64'h4F80_0000, 1'b1, 1'b0));
`endif

        // Backpressure: six back-to-back operands, consumer stalls cycles 4..9.
        stall_seen = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_m(32'd1000 * 32'(i + 1) + 32'd7, 3'(i), 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        check_val("bp_stall_seen", 64'(stall_seen > 0), 64'd1);

        // Random operands under random consumer backpressure.
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    rand_op(d, rm);
`ifdef CVT_UNSIGNED_EN
                    u = 1'($urandom_range(0, 1));
`else
                    u = 1'b0;
`endif
                    send_m(d, rm, u);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join

        // Narrow format: overflow handling.
        send_h(32'd70000, 3'd0, mk(64'h7C00, 1'b1, 1'b1));
        send_h(32'd70000, 3'd1, mk(64'h7BFF, 1'b1, 1'b1));
        send_h(32'hFFFE_EE90, 3'd3, mk(64'hFBFF, 1'b1, 1'b1));
        send_h(32'd1, 3'd0, mk(64'h3C00, 1'b0, 1'b0));
        for (int i = 0; i < 30; i++) begin
            rand_op(d, rm);
            send_h(d, rm, model(d, rm, 1'b0, 5, 10));
        end

        // Let everything drain before the reset test.
        for (int i = 0; i < 300 && (sb.size() != 0 || sbh.size() != 0); i++) @(posedge clk);
        #1;
        check_val("pre_rst_drain", 64'(sb.size() + sbh.size()), 64'd0);

        // Reset with three operands in flight.
        send_m(32'd11, 3'd0, 1'b0);
        send_m(32'd22, 3'd0, 1'b0);
        send_m(32'd33, 3'd0, 1'b0);
        check_val("rst_pre_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check_val("rst_async_valid", 64'(out_valid), 64'd0);
        check_val("rst_async_data", 64'(out_data), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("rst_no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        send(32'hFFFF_FFFE, 3'd0, 1'b0, mk(64'hC000_0000, 1'b0, 1'b0));
        check_val("rst_lat_e0", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check_val("rst_lat_e1", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check_val("rst_lat_e2", 64'(out_valid), 64'd1);

        for (int i = 0; i < 300 && (sb.size() != 0 || sbh.size() != 0); i++) @(posedge clk);
        #1;
        check_val("final_drain", 64'(sb.size() + sbh.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
